// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive path (tdm_demux and its
// slot counter).
package tdm_pkg;

  // Receiver state: waiting for a start-of-frame, or collecting slots.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  // Width of the error counter exposed when TDM_DEMUX_ERR_CNT_EN is defined.
  localparam int ERR_CNT_W = 8;

  // Slot counter width for a frame of n_ch channels.
  function automatic int slot_cnt_w(input int n_ch);
    return $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for the TDM receiver. Supports clear, load-to-1
// (slot 0 has just been captured) and increment, and flags the last slot.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int SLOT_W = slot_cnt_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] count,
  output logic              tc
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

  logic [SLOT_W-1:0] count_r;

  // Counter register; clear wins over load, load wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load1) begin
      count_r <= SLOT_W'(1);
    end else if (inc) begin
      count_r <= count_r + SLOT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == LAST_SLOT);

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects one beat per channel, framed by in_sof, and
// presents the whole frame on out_data one cycle after the last beat.
// Slots 0..N_CH-2 wait in a shadow buffer so out_data changes atomically.
// Optional: define TDM_DEMUX_ERR_CNT_EN to add a saturating 8-bit err_cnt
// output counting frame_err pulses.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   out_valid,
  output logic                   frame_err,
  output logic                   busy
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

  localparam int SLOT_W = slot_cnt_w(N_CH);

  tdm_state_e              state_r;
  logic [DATA_W-1:0]       shadow_r [N_CH-1];
  logic [N_CH*DATA_W-1:0]  out_data_r;
  logic                    out_valid_r;
  logic                    frame_err_r;

  logic [SLOT_W-1:0]       slot_s;
  logic                    tc_s;
  logic                    load1_s;
  logic                    inc_s;
  logic                    clr_s;
  logic                    err_s;
  logic                    done_s;
  logic [N_CH*DATA_W-1:0]  frame_s;

  tdm_slot_counter #(
    .N_CH   (N_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .load1   (load1_s),
    .inc     (inc_s),
    .count   (slot_s),
    .tc      (tc_s)
  );

  // Decode the current beat into counter/buffer actions and error/done events.
  always_comb begin
    load1_s = 1'b0;
    inc_s   = 1'b0;
    clr_s   = 1'b0;
    err_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            load1_s = 1'b1;
          end else begin
            // Data with no frame open is an orphan beat.
            err_s = 1'b1;
          end
        end else begin
          load1_s = 1'b0;
        end
      end
      RECV: begin
        if (in_valid) begin
          if (in_sof) begin
            // Early SOF: drop the partial frame and restart at slot 0.
            load1_s = 1'b1;
            err_s   = 1'b1;
          end else if (tc_s) begin
            clr_s  = 1'b1;
            done_s = 1'b1;
          end else begin
            inc_s = 1'b1;
          end
        end else begin
          inc_s = 1'b0;
        end
      end
      default: begin
        clr_s = 1'b1;
      end
    endcase
  end

  // Assemble the completed frame: shadowed slots plus the final beat on top.
  always_comb begin
    frame_s = '0;
    for (int k = 0; k < N_CH - 1; k++) begin
      frame_s[k*DATA_W +: DATA_W] = shadow_r[k];
    end
    frame_s[(N_CH-1)*DATA_W +: DATA_W] = in_data;
  end

  // Shadow buffer: slot 0 on any accepted SOF, later slots as they arrive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_CH - 1; k++) begin
        shadow_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH - 1; k++) begin
        if (load1_s && (k == 0)) begin
          shadow_r[k] <= in_data;
        end else if (inc_s && (slot_s == SLOT_W'(k))) begin
          shadow_r[k] <= in_data;
        end else begin
          shadow_r[k] <= shadow_r[k];
        end
      end
    end
  end

  // Receiver FSM with registered frame output and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      out_valid_r <= done_s;
      frame_err_r <= err_s;
      if (done_s) begin
        out_data_r <= frame_s;
      end else begin
        out_data_r <= out_data_r;
      end
      case (state_r)
        IDLE: begin
          if (load1_s) begin
            state_r <= RECV;
          end else begin
            state_r <= IDLE;
          end
        end
        RECV: begin
          if (done_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= RECV;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Saturating count of framing errors, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= '0;
    end else if (err_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  // Error counter not present in this build.
`endif

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = (state_r == RECV);

endmodule
